kbd_host_seq: RTL and testbench

Host-to-keyboard command sequencer for the PS/2 keyboard port. It arbitrates between keyboard-reset and LED-update requests from the CPU-side register logic. It drives the open-collector PS/2 clock and data lines to transmit command bytes, and collects the keyboard's ACK, RESEND and BAT replies. While it owns the link it asserts RX_HOLD so the scan-code receiver ignores the traffic.

---
 rtl/kbd_host_seq.sv | 268 ++++++++++++++++++++++++++
 tb/tb_kbd_host_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_host_seq.sv
// PS/2 host-to-keyboard command sequencer: arbitrates reset/LED requests,
// clocks command bytes out on the open-collector lines and decodes the replies.
module kbd_host_seq #(
    parameter int INHIBIT_CYC = 4200,
    parameter int TIMEOUT_CYC = 840000,
    parameter int BAT_CYC     = 21000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLK42,
    input  logic       RST,
    input  logic       KBD_CC,
    input  logic       KBD_DD,
    output logic       KBD_CC_OE,
    output logic       KBD_DD_OE,
    input  logic       REQ_RST,
    input  logic       REQ_LED,
    input  logic [2:0] LED_VAL,
    output logic       RX_HOLD,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       BAT_OK
);

    localparam int TMO_MAX = (BAT_CYC > TIMEOUT_CYC) ? BAT_CYC : TIMEOUT_CYC;
    localparam int TW = $clog2(TMO_MAX + 1);
    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_TX, S_ACK, S_RX, S_DECODE
    } state_t;

    typedef enum logic [1:0] {B_RST, B_CMD, B_LED} byte_t;

    state_t          state;
    byte_t           stage;
    logic            pend_rst, pend_led;
    logic            bat_phase;
    logic [RW-1:0]   retry_cnt;
    logic [IW-1:0]   inh_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [3:0]      tx_cnt, rx_cnt;
    logic [7:0]      tx_byte;
    logic [10:0]     rx_sh;

    logic cc_p0, cc_p1, cc_p2, dd_p0, dd_p1;
    logic fall;
    logic tmo_zero, give_up;
    logic retry_ev, fatal_ev;
    logic rx_ok, accept_fa, accept_aa, load_led;
    logic [7:0] rx_byte;
    logic [TW-1:0] tmo_reload;

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic frame_ok(input logic [10:0] f);
        return ~f[0] & f[10] & (^f[9:1]);
    endfunction

    // stage p0/p1: line synchronizers, p2: previous clock for edge detect
    always_ff @(posedge CLK42 or posedge RST) begin
        if (RST) begin
            cc_p0 <= 1'b1;
            cc_p1 <= 1'b1;
            cc_p2 <= 1'b1;
            dd_p0 <= 1'b1;
            dd_p1 <= 1'b1;
        end else begin
            cc_p0 <= KBD_CC;
            cc_p1 <= cc_p0;
            cc_p2 <= cc_p1;
            dd_p0 <= KBD_DD;
            dd_p1 <= dd_p0;
        end
    end

    assign fall       = cc_p2 & ~cc_p1;
    assign tmo_zero   = (tmo_cnt == '0);
    assign give_up    = (retry_cnt >= RW'(MAX_RETRY));
    assign rx_byte    = rx_sh[8:1];
    assign rx_ok      = frame_ok(rx_sh);
    assign accept_fa  = (state == S_DECODE) & rx_ok & (rx_byte == 8'hFA) & ~bat_phase;
    assign accept_aa  = (state == S_DECODE) & rx_ok & (rx_byte == 8'hAA) & bat_phase;
    assign load_led   = accept_fa & (stage == B_CMD);
    assign tmo_reload = bat_phase ? TW'(BAT_CYC - 1) : TW'(TIMEOUT_CYC - 1);

    assign RX_HOLD = (state != S_IDLE);
    assign BUSY    = (state != S_IDLE) | pend_rst | pend_led;

    // Failure classification: retry_ev resends the current byte, fatal_ev abandons.
    always_comb begin
        retry_ev = 1'b0;
        fatal_ev = 1'b0;
        case (state)
            S_START, S_TX: retry_ev = ~fall & tmo_zero;
            S_ACK:         retry_ev = fall ? dd_p1 : tmo_zero;
            S_RX: begin
                if (~fall & tmo_zero) begin
                    if (bat_phase) fatal_ev = 1'b1;
                    else           retry_ev = 1'b1;
                end
            end
            S_DECODE: begin
                if (bat_phase && rx_ok && rx_byte == 8'hFC) fatal_ev = 1'b1;
                else if (!accept_fa && !accept_aa)          retry_ev = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK42) begin
        if (state == S_RX && fall)
            rx_sh <= {dd_p1, rx_sh[10:1]};
        if (state == S_IDLE)
            tx_byte <= (pend_rst | REQ_RST) ? 8'hFF : 8'hED;
        else if (load_led)
            tx_byte <= {5'b0, LED_VAL};
    end

    always_ff @(posedge CLK42 or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            stage     <= B_RST;
            KBD_CC_OE <= 1'b0;
            KBD_DD_OE <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            BAT_OK    <= 1'b0;
            pend_rst  <= 1'b0;
            pend_led  <= 1'b0;
            bat_phase <= 1'b0;
            retry_cnt <= '0;
            inh_cnt   <= '0;
            tmo_cnt   <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
        end else begin
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            pend_rst <= pend_rst | REQ_RST;
            pend_led <= pend_led | REQ_LED;
            if (fatal_ev || (retry_ev && give_up)) begin
                state     <= S_IDLE;
                ERR       <= 1'b1;
                KBD_CC_OE <= 1'b0;
                KBD_DD_OE <= 1'b0;
                bat_phase <= 1'b0;
            end else if (retry_ev) begin
                retry_cnt <= retry_cnt + RW'(1);
                state     <= S_INHIBIT;
                KBD_CC_OE <= 1'b1;
                KBD_DD_OE <= 1'b0;
                inh_cnt   <= IW'(INHIBIT_CYC - 1);
                bat_phase <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (pend_rst || REQ_RST || pend_led || REQ_LED) begin
                            if (pend_rst || REQ_RST) begin
                                pend_rst <= 1'b0;
                                stage    <= B_RST;
                                BAT_OK   <= 1'b0;
                            end else begin
                                pend_led <= 1'b0;
                                stage    <= B_CMD;
                            end
                            retry_cnt <= '0;
                            state     <= S_INHIBIT;
                            KBD_CC_OE <= 1'b1;
                            KBD_DD_OE <= 1'b0;
                            inh_cnt   <= IW'(INHIBIT_CYC - 1);
                            bat_phase <= 1'b0;
                        end
                    end
                    S_INHIBIT: begin
                        if (inh_cnt == '0) begin
                            state     <= S_START;
                            KBD_CC_OE <= 1'b0;
                            KBD_DD_OE <= 1'b1;
                            tmo_cnt   <= TW'(TIMEOUT_CYC - 1);
                        end else begin
                            inh_cnt <= inh_cnt - IW'(1);
                        end
                    end
                    S_START: begin
                        if (fall) begin
                            state     <= S_TX;
                            KBD_DD_OE <= ~tx_byte[0];
                            tx_cnt    <= 4'd1;
                            tmo_cnt   <= tmo_reload;
                        end else begin
                            tmo_cnt <= tmo_cnt - TW'(1);
                        end
                    end
                    S_TX: begin
                        if (fall) begin
                            tmo_cnt <= tmo_reload;
                            tx_cnt  <= tx_cnt + 4'd1;
                            if (tx_cnt == 4'd9) begin
                                KBD_DD_OE <= 1'b0;
                                state     <= S_ACK;
                            end else if (tx_cnt == 4'd8) begin
                                KBD_DD_OE <= ~odd_par(tx_byte);
                            end else begin
                                KBD_DD_OE <= ~tx_byte[tx_cnt[2:0]];
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt - TW'(1);
                        end
                    end
                    S_ACK: begin
                        if (fall) begin
                            state   <= S_RX;
                            rx_cnt  <= 4'd0;
                            tmo_cnt <= tmo_reload;
                        end else begin
                            tmo_cnt <= tmo_cnt - TW'(1);
                        end
                    end
                    S_RX: begin
                        if (fall) begin
                            tmo_cnt <= tmo_reload;
                            rx_cnt  <= rx_cnt + 4'd1;
                            if (rx_cnt == 4'd10)
                                state <= S_DECODE;
                        end else begin
                            tmo_cnt <= tmo_cnt - TW'(1);
                        end
                    end
                    S_DECODE: begin
                        if (accept_fa) begin
                            case (stage)
                                B_CMD: begin
                                    stage     <= B_LED;
                                    retry_cnt <= '0;
                                    state     <= S_INHIBIT;
                                    KBD_CC_OE <= 1'b1;
                                    KBD_DD_OE <= 1'b0;
                                    inh_cnt   <= IW'(INHIBIT_CYC - 1);
                                end
                                B_LED: begin
                                    state <= S_IDLE;
                                    DONE  <= 1'b1;
                                end
                                default: begin
                                    bat_phase <= 1'b1;
                                    state     <= S_RX;
                                    rx_cnt    <= 4'd0;
                                    tmo_cnt   <= TW'(BAT_CYC - 1);
                                end
                            endcase
                        end else if (accept_aa) begin
                            BAT_OK    <= 1'b1;
                            DONE      <= 1'b1;
                            bat_phase <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kbd_host_seq.sv
// Bench for kbd_host_seq: behavioural PS/2 keyboard on wired-AND lines plus an
// expected-byte queue derived from the command rules.
module tb_kbd_host_seq;

    localparam int INH = 40;
    localparam int TMO = 400;
    localparam int BAT = 3000;
    localparam int MR  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_rst = 1'b0, req_led = 1'b0;
    logic [2:0] led_val = 3'd0;
    logic dev_cc = 1'b1, dev_dd = 1'b1;
    logic cc_oe, dd_oe, rx_hold, busy, done, err, bat_ok;
    logic kbd_cc, kbd_dd;

    assign kbd_cc = ~cc_oe & dev_cc;
    assign kbd_dd = ~dd_oe & dev_dd;

    always #5 clk = ~clk;

    kbd_host_seq #(
        .INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .BAT_CYC(BAT), .MAX_RETRY(MR)
    ) dut (
        .CLK42(clk), .RST(rst), .KBD_CC(kbd_cc), .KBD_DD(kbd_dd),
        .KBD_CC_OE(cc_oe), .KBD_DD_OE(dd_oe),
        .REQ_RST(req_rst), .REQ_LED(req_led), .LED_VAL(led_val),
        .RX_HOLD(rx_hold), .BUSY(busy), .DONE(done), .ERR(err), .BAT_OK(bat_ok)
    );

    int checks = 0;
    int failures = 0;
    int ps2_h = 8;
    logic [7:0] exp_q[$];

    int done_cnt = 0, done_cyc = 0, err_cnt = 0;
    logic done_q = 1'b0, err_q = 1'b0, cc_q = 1'b0;
    int cc_run = 0, inh_n = 0, inh_bad = 0;
    int age = 0, err_age = -1;
    logic gap_watch = 1'b0;
    int gap_base = 0, busy_gap = 0;

    // Passive monitor: pulse counts, inhibit run lengths, START age, BUSY gaps
    always @(negedge clk) begin
        done_q <= done;
        err_q  <= err;
        cc_q   <= cc_oe;
        if (done) done_cyc <= done_cyc + 1;
        if (done && !done_q) done_cnt <= done_cnt + 1;
        if (err && !err_q) begin
            err_cnt <= err_cnt + 1;
            err_age <= (cc_q && !cc_oe) ? 0 : age + 1;
        end
        age <= (cc_q && !cc_oe) ? 0 : age + 1;
        if (cc_oe) begin
            cc_run <= cc_run + 1;
        end else if (cc_run != 0) begin
            inh_n <= inh_n + 1;
            if (cc_run != INH) inh_bad <= inh_bad + 1;
            cc_run <= 0;
        end
        if (gap_watch && !busy &&
            ((done_cnt == gap_base && done) || (done_cnt == gap_base + 1 && !done)))
            busy_gap <= busy_gap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic r, input logic l);
        req_rst = r;
        req_led = l;
        cyc(1);
        req_rst = 1'b0;
        req_led = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!(cc_oe === 1'b0 && dd_oe === 1'b1) && n < 5000) begin
            cyc(1);
            n++;
        end
        chk({tag, "_start_seen"}, (n < 5000), 1);
    endtask

    // Keyboard receives one host frame, acknowledges it, and checks it against the queue
    task automatic dev_rx(input string tag);
        logic [9:0] f;
        logic [7:0] e;
        wait_start(tag);
        cyc(3);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) begin
                dev_dd = 1'b0;
                cyc(2);
            end
            dev_cc = 1'b0;
            cyc(ps2_h);
            dev_cc = 1'b1;
            if (i <= 10) f[i-1] = kbd_dd;
            cyc(ps2_h);
        end
        dev_dd = 1'b1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_byte"}, {24'd0, f[7:0]}, {24'd0, e});
        chk({tag, "_parity_odd"}, {31'd0, ^f[8:0]}, 1);
        chk({tag, "_stop"}, {31'd0, f[9]}, 1);
    endtask

    task automatic dev_tx(input logic [7:0] b);
        logic [10:0] fr;
        fr = {1'b1, ~^b, b, 1'b0};
        cyc($urandom_range(3, 20));
        for (int i = 0; i <= 10; i++) begin
            dev_dd = fr[i];
            cyc(ps2_h);
            dev_cc = 1'b0;
            cyc(ps2_h);
            dev_cc = 1'b1;
        end
        cyc(ps2_h);
        dev_dd = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int base);
        int n;
        n = 0;
        while (done_cnt <= base && n < 8000) begin
            cyc(1);
            n++;
        end
        chk({tag, "_done_seen"}, (done_cnt > base), 1);
    endtask

    // Full LED command; LED_VAL changes after the request to show late sampling
    task automatic run_led(input string tag);
        logic [2:0] led;
        int base, ebase;
        led = 3'($urandom_range(0, 7));
        ps2_h = $urandom_range(6, 14);
        base = done_cnt;
        ebase = err_cnt;
        led_val = ~led;
        pulse(1'b0, 1'b1);
        chk({tag, "_busy_n1"}, {29'd0, busy, cc_oe, rx_hold}, 3'b111);
        exp_q.push_back(8'hED);
        dev_rx({tag, "_ed"});
        led_val = led;
        dev_tx(8'hFA);
        exp_q.push_back({5'b0, led});
        dev_rx({tag, "_val"});
        dev_tx(8'hFA);
        wait_done(tag, base);
        cyc(2);
        chk({tag, "_one_done"}, done_cnt, base + 1);
        chk({tag, "_done_width"}, done_cyc, done_cnt);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 0);
        chk({tag, "_no_err"}, err_cnt, ebase);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, ebase, ibase, n;

        cyc(3);
        chk("reset_outputs", {25'd0, cc_oe, dd_oe, rx_hold, busy, done, err, bat_ok}, 0);
        rst = 1'b0;
        cyc(2);
        chk("post_reset_idle", {29'd0, busy, rx_hold, cc_oe}, 0);

        for (int t = 0; t < 3; t++) run_led($sformatf("led%0d", t));

        // Reset command with a delayed BAT completion
        base = done_cnt;
        ebase = err_cnt;
        pulse(1'b1, 1'b0);
        exp_q.push_back(8'hFF);
        dev_rx("rst_ff");
        chk("bat_ok_cleared", {31'd0, bat_ok}, 0);
        dev_tx(8'hFA);
        cyc(1000);
        chk("bat_ok_during", {31'd0, bat_ok}, 0);
        chk("rst_still_busy", {31'd0, busy}, 1);
        dev_tx(8'hAA);
        wait_done("rst", base);
        chk("bat_ok_at_done", {31'd0, bat_ok}, 1);
        chk("rst_no_err", err_cnt, ebase);

        // RESEND on the first command byte
        base = done_cnt;
        ebase = err_cnt;
        ibase = inh_n;
        ps2_h = $urandom_range(6, 14);
        led_val = 3'b010;
        pulse(1'b0, 1'b1);
        exp_q.push_back(8'hED);
        dev_rx("fe_first");
        dev_tx(8'hFE);
        exp_q.push_back(8'hED);
        dev_rx("fe_resend");
        dev_tx(8'hFA);
        exp_q.push_back(8'h02);
        dev_rx("fe_val");
        dev_tx(8'hFA);
        wait_done("fe", base);
        chk("fe_no_err", err_cnt, ebase);
        chk("fe_inhibits", inh_n - ibase, 3);

        // Silent keyboard: four attempts then abandon
        ebase = err_cnt;
        base = done_cnt;
        ibase = inh_n;
        pulse(1'b0, 1'b1);
        for (int a = 0; a < 4; a++) begin
            n = 0;
            while (cc_oe !== 1'b1 && n < 2000) begin
                cyc(1);
                n++;
            end
            wait_start($sformatf("silent%0d", a));
        end
        n = 0;
        while (err_cnt == ebase && n < TMO + INH + 100) begin
            cyc(1);
            n++;
        end
        cyc(2);
        chk("silent_err_once", err_cnt, ebase + 1);
        chk("silent_attempts", inh_n - ibase, 4);
        chk("inhibit_lengths", inh_bad, 0);
        chk("silent_err_age", err_age, TMO);
        chk("silent_lines_released", {30'd0, cc_oe, dd_oe}, 0);
        chk("silent_not_busy", {31'd0, busy}, 0);
        chk("silent_no_done", done_cnt, base);

        // Simultaneous requests: reset first, LED second, BUSY continuous
        base = done_cnt;
        ebase = err_cnt;
        ps2_h = $urandom_range(6, 14);
        led_val = 3'b110;
        pulse(1'b1, 1'b1);
        gap_base = done_cnt;
        gap_watch = 1'b1;
        exp_q.push_back(8'hFF);
        dev_rx("both_ff");
        dev_tx(8'hFA);
        cyc(200);
        dev_tx(8'hAA);
        exp_q.push_back(8'hED);
        dev_rx("both_ed");
        chk("both_rst_done_first", done_cnt, base + 1);
        dev_tx(8'hFA);
        exp_q.push_back(8'h06);
        dev_rx("both_val");
        dev_tx(8'hFA);
        wait_done("both", base + 1);
        cyc(2);
        gap_watch = 1'b0;
        chk("both_two_done", done_cnt, base + 2);
        chk("both_busy_gap", busy_gap, 0);
        chk("both_bat_ok", {31'd0, bat_ok}, 1);
        chk("both_no_err", err_cnt, ebase);

        // Asynchronous reset during data bit 4 of 0xED
        ps2_h = 8;
        pulse(1'b0, 1'b1);
        wait_start("arst");
        cyc(3);
        for (int i = 1; i <= 5; i++) begin
            dev_cc = 1'b0;
            cyc(ps2_h);
            dev_cc = 1'b1;
            if (i < 5) cyc(ps2_h);
        end
        chk("arst_bit4_driven", {30'd0, cc_oe, dd_oe}, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_lines_released", {30'd0, cc_oe, dd_oe}, 0);
        chk("arst_idle", {29'd0, busy, rx_hold, bat_ok}, 0);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        run_led("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
